// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } timer_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the countdown timer: strobes once every presc_div+1 enabled cycles.
// Only instantiated when TIMER_PRESCALE_EN is defined.
module timer_prescaler #(
  parameter int unsigned PRESC_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [PRESC_WIDTH-1:0] presc_div,
  output logic                   strobe
);

  logic [PRESC_WIDTH-1:0] cnt_q, cnt_d;

  assign strobe = enable && !clear && (cnt_q == presc_div);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (strobe) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + PRESC_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Reloadable down-counter emitting a one-cycle tick at each terminal count, one-shot or periodic.
// Optional prescaler on the count step is enabled by defining TIMER_PRESCALE_EN.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = 8,
  parameter int unsigned PRESC_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   load,
  input  logic [CNT_WIDTH-1:0]   load_value,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   periodic,
`ifdef TIMER_PRESCALE_EN
  input  logic [PRESC_WIDTH-1:0] presc_div,
`endif
  output logic [CNT_WIDTH-1:0]   count_out,
  output logic                   tick,
  output logic                   busy
);

  timer_state_e         state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] reload_q, reload_d;
  logic                 tick_q, tick_d;
  logic                 step;

`ifdef TIMER_PRESCALE_EN
  timer_prescaler #(
    .PRESC_WIDTH(PRESC_WIDTH)
  ) u_prescaler (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable && (state_q == ST_RUN)),
    .clear     (start || load || stop),
    .presc_div (presc_div),
    .strobe    (step)
  );
`else
  assign step = enable;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tick_d   = 1'b0;

    // stop only affects the state, so a simultaneous load still captures its value.
    if (stop && (state_q == ST_RUN)) begin
      state_d = ST_IDLE;
    end

    if (load) begin
      reload_d = load_value;
      count_d  = load_value;
    end else if (stop) begin
      count_d = count_q;
    end else if (start && (state_q != ST_RUN)) begin
      if (count_q != '0) begin
        state_d = ST_RUN;
      end else if (reload_q != '0) begin
        count_d = reload_q;
        state_d = ST_RUN;
      end
    end else if ((state_q == ST_RUN) && step) begin
      if (count_q > CNT_WIDTH'(1)) begin
        count_d = count_q - CNT_WIDTH'(1);
      end else if (count_q == CNT_WIDTH'(1)) begin
        tick_d = 1'b1;
        if (periodic) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = ST_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tick_q   <= tick_d;
    end
  end

  assign count_out = count_q;
  assign tick      = tick_q;
  assign busy      = (state_q == ST_RUN);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed vector bench for countdown_timer; prescaler sequence runs when TIMER_PRESCALE_EN is defined.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable, load, start, stop, periodic;
  logic [7:0] load_value;
  logic [7:0] count_out;
  logic       tick, busy;
`ifdef TIMER_PRESCALE_EN
  logic [3:0] presc_div;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  countdown_timer #(
    .CNT_WIDTH   (8),
    .PRESC_WIDTH (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .stop       (stop),
    .periodic   (periodic),
`ifdef TIMER_PRESCALE_EN
    .presc_div  (presc_div),
`endif
    .count_out  (count_out),
    .tick       (tick),
    .busy       (busy)
  );

  typedef struct packed {
    logic       ld;
    logic [7:0] lv;
    logic       st;
    logic       sp;
    logic       en;
    logic       per;
    logic [7:0] c;
    logic       t;
    logic       b;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ld, input logic [7:0] lv, input logic st, input logic sp,
                     input logic en, input logic per, input logic [7:0] c, input logic t,
                     input logic b);
    vec_t v;
    v = '{ld: ld, lv: lv, st: st, sp: sp, en: en, per: per, c: c, t: t, b: b};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] c, input logic t, input logic b);
    total++;
    if (count_out !== c) begin
      bad++;
      $display("FAIL %s count_out: got %0d want %0d", name, count_out, c);
    end
    total++;
    if (tick !== t) begin
      bad++;
      $display("FAIL %s tick: got %b want %b", name, tick, t);
    end
    total++;
    if (busy !== b) begin
      bad++;
      $display("FAIL %s busy: got %b want %b", name, busy, b);
    end
  endtask

  task automatic drive(input logic ld, input logic [7:0] lv, input logic st, input logic sp,
                       input logic en, input logic per);
    @(negedge clk);
    load = ld; load_value = lv; start = st; stop = sp; enable = en; periodic = per;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    enable = 0; load = 0; start = 0; stop = 0; periodic = 0; load_value = '0;
`ifdef TIMER_PRESCALE_EN
    presc_div = 4'd0;
`endif

    //    ld lv st sp en per   c  t  b
    add(1, 3, 0, 0, 0, 1,  3, 0, 0);  // load 3
    add(0, 0, 1, 0, 0, 1,  3, 0, 1);  // start
    add(0, 0, 0, 0, 1, 1,  2, 0, 1);
    add(0, 0, 0, 0, 1, 1,  1, 0, 1);
    add(0, 0, 0, 0, 1, 1,  3, 1, 1);  // periodic reload with tick
    add(0, 0, 0, 0, 1, 1,  2, 0, 1);
    add(0, 0, 0, 0, 1, 1,  1, 0, 1);
    add(0, 0, 0, 0, 1, 1,  3, 1, 1);
    add(1, 4, 0, 1, 1, 1,  4, 0, 0);  // stop+load -> IDLE with new value
    add(0, 0, 1, 0, 0, 0,  4, 0, 1);
    add(0, 0, 0, 0, 1, 0,  3, 0, 1);
    add(0, 0, 0, 0, 1, 0,  2, 0, 1);
    add(0, 0, 0, 0, 1, 0,  1, 0, 1);
    add(0, 0, 0, 0, 1, 0,  0, 1, 0);  // one-shot terminal -> DONE
    add(0, 0, 0, 0, 1, 0,  0, 0, 0);  // DONE holds 0
    add(0, 0, 1, 0, 0, 0,  4, 0, 1);  // restart from reload
    add(0, 0, 0, 0, 1, 0,  3, 0, 1);
    add(0, 0, 0, 0, 1, 0,  2, 0, 1);
    add(0, 0, 0, 0, 0, 0,  2, 0, 1);  // enable low holds
    add(0, 0, 0, 0, 0, 0,  2, 0, 1);
    add(0, 0, 0, 0, 0, 0,  2, 0, 1);
    add(0, 0, 0, 1, 0, 0,  2, 0, 0);  // stop
    add(0, 0, 0, 0, 1, 0,  2, 0, 0);  // IDLE ignores enable
    add(0, 0, 1, 0, 0, 0,  2, 0, 1);  // resume from 2
    add(0, 0, 0, 0, 1, 0,  1, 0, 1);
    add(1, 6, 0, 0, 1, 0,  6, 0, 1);  // load on terminal cycle: no tick
    add(0, 0, 0, 0, 1, 0,  5, 0, 1);
    add(1, 0, 0, 1, 0, 0,  0, 0, 0);  // zero reload, IDLE
    add(0, 0, 1, 0, 0, 0,  0, 0, 0);  // start ignored
    add(0, 0, 1, 0, 1, 0,  0, 0, 0);
    add(1, 1, 0, 0, 0, 0,  1, 0, 0);
    add(0, 0, 1, 0, 0, 0,  1, 0, 1);
    add(0, 0, 0, 1, 1, 0,  1, 0, 0);  // stop on terminal cycle: no tick

    #12;
    check("reset", 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].sp, vecs[i].en, vecs[i].per);
      check($sformatf("vec%0d", i), vecs[i].c, vecs[i].t, vecs[i].b);
    end

    // Asynchronous reset while running at 5.
    drive(1, 8'd5, 0, 0, 0, 1);
    drive(0, 8'd0, 1, 0, 0, 1);
    check("pre_reset", 8'd5, 1'b0, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(0, 8'd0, 1, 0, 1, 1);
    check("reload_cleared", 8'd0, 1'b0, 1'b0);

`ifdef TIMER_PRESCALE_EN
    begin
      logic [7:0] exp_c [12];
      logic       exp_t [12];
      presc_div = 4'd2;
      drive(1, 8'd2, 0, 0, 0, 1);
      drive(0, 8'd0, 1, 0, 0, 1);
      check("presc_start", 8'd2, 1'b0, 1'b1);
      for (int k = 0; k < 12; k++) begin
        // Decrement on every third enabled cycle, tick every sixth.
        exp_c[k] = ((k % 6) < 2) ? 8'd2 : (((k % 6) < 5) ? 8'd1 : 8'd2);
        exp_t[k] = ((k % 6) == 5);
      end
      for (int k = 0; k < 12; k++) begin
        drive(0, 8'd0, 0, 0, 1, 1);
        check($sformatf("presc%0d", k), exp_c[k], exp_t[k], 1'b1);
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
